// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: frame state encoding,
// parity-mode constants and the grant-index width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // A single requester still gets a one-bit index so port widths never collapse to zero.
  function automatic int gw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last committed winner and
// the pointer only moves when the owner's frame has fully completed.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic              advance,
  input  logic [gw(N)-1:0]  advance_id,
  output logic [N-1:0]      grant,
  output logic [gw(N)-1:0]  winner
);

  localparam int W = gw(N);

  logic [W-1:0] last;
  logic [W:0]   slot;
  logic [W-1:0] pick;
  logic         found;

  // Starting last at N-1 makes requester 0 the first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= W'(N - 1);
    end else if (advance) begin
      last <= advance_id;
    end
  end

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    slot   = '0;
    pick   = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, last} + (W+1)'(k + 1);
      if (slot >= (W+1)'(N)) begin
        slot = slot - (W+1)'(N);
      end
      pick = slot[W-1:0];
      if (!found && req[pick]) begin
        found       = 1'b1;
        grant[pick] = 1'b1;
        winner      = pick;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmit line between NREQ byte sources: accepts one byte per
// frame, drives the external baud generator enable and serialises the frame.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATA_BITS-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      baud_en,
  input  logic                      baud_tick,
  output logic                      txd,
  output logic                      busy,
  output logic [gw(NREQ)-1:0]       grant_id
);

  localparam int GW = gw(NREQ);

  tx_state_t              state, state_d;
  logic [DATA_BITS-1:0]   shift, shift_d;
  logic [3:0]             bit_cnt, bit_cnt_d;
  logic [1:0]             stop_cnt, stop_cnt_d;
  logic                   par_bit, par_bit_d;
  logic                   txd_d;
  logic [GW-1:0]          grant_id_d;
  logic [NREQ-1:0]        arb_grant;
  logic [GW-1:0]          arb_winner;
  logic                   advance;
  logic [DATA_BITS-1:0]   sel_data;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_valid),
    .advance    (advance),
    .advance_id (grant_id),
    .grant      (arb_grant),
    .winner     (arb_winner)
  );

  assign req_ready = (state == S_IDLE) ? arb_grant : '0;
  assign sel_data  = req_data[arb_winner*DATA_BITS +: DATA_BITS];

  // Next-state logic; txd is derived from the next state so the pin stays registered.
  always_comb begin
    state_d    = state;
    shift_d    = shift;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_bit_d  = par_bit;
    grant_id_d = grant_id;
    advance    = 1'b0;
    txd_d      = 1'b1;

    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          state_d    = S_START;
          shift_d    = sel_data;
          par_bit_d  = (PARITY == PAR_ODD) ? ~(^sel_data) : ^sel_data;
          grant_id_d = arb_winner;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            state_d    = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            stop_cnt_d = '0;
          end else begin
            shift_d   = shift >> 1;
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt == 2'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            advance = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_bit_d;
      default:  txd_d = 1'b1;
    endcase
  end

  // Reset drops the frame outright; the line returns high and nothing is replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_bit  <= 1'b0;
      grant_id <= '0;
      txd      <= 1'b1;
      baud_en  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      par_bit  <= par_bit_d;
      grant_id <= grant_id_d;
      txd      <= txd_d;
      baud_en  <= (state_d != S_IDLE);
      busy     <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: four instances cover default framing,
// even parity, odd parity and two stop bits, each with its own baud generator.
module tb_uart_tx_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  valid    [4];
  logic [15:0] data     [4];
  logic [1:0]  ready    [4];
  logic        baud_en  [4];
  logic        baud_tick[4];
  logic        spur     [4];
  logic        txd      [4];
  logic        busy     [4];
  logic [0:0]  gid      [4];

  int compared;
  int mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: one-cycle tick every 16 clks while enabled, plus an optional forced pulse.
  for (genvar g = 0; g < 4; g++) begin : gen_baud
    logic [3:0] cnt;
    always_ff @(posedge clk) begin
      if (!baud_en[g]) cnt <= 4'd0;
      else             cnt <= cnt + 4'd1;
    end
    assign baud_tick[g] = (baud_en[g] && cnt == 4'd15) || spur[g];
  end

  uart_tx_sched #(.NREQ(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_plain (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[0]), .req_data(data[0]), .req_ready(ready[0]),
    .baud_en(baud_en[0]), .baud_tick(baud_tick[0]), .txd(txd[0]), .busy(busy[0]), .grant_id(gid[0]));

  uart_tx_sched #(.NREQ(2), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[1]), .req_data(data[1]), .req_ready(ready[1]),
    .baud_en(baud_en[1]), .baud_tick(baud_tick[1]), .txd(txd[1]), .busy(busy[1]), .grant_id(gid[1]));

  uart_tx_sched #(.NREQ(2), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[2]), .req_data(data[2]), .req_ready(ready[2]),
    .baud_en(baud_en[2]), .baud_tick(baud_tick[2]), .txd(txd[2]), .busy(busy[2]), .grant_id(gid[2]));

  uart_tx_sched #(.NREQ(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[3]), .req_data(data[3]), .req_ready(ready[3]),
    .baud_en(baud_en[3]), .baud_tick(baud_tick[3]), .txd(txd[3]), .busy(busy[3]), .grant_id(gid[3]));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [1:0] v, input logic [15:0] d);
    valid[i] = v;
    data[i]  = d;
  endtask

  // Called on an IDLE negedge; returns on the negedge of the first START cycle.
  task automatic acceptFrame(input int i, input logic [1:0] v, input logic [15:0] d,
                             input logic [1:0] exp_ready, input logic exp_gid, input string tag);
    applyStimulus(i, v, d);
    #1;
    checkOutput({tag, "_ready"}, 32'(ready[i]), 32'(exp_ready));
    @(negedge clk);
    checkOutput({tag, "_ready_gone"}, 32'(ready[i]), 32'd0);
    checkOutput({tag, "_gid"}, 32'(gid[i]), 32'(exp_gid));
    checkOutput({tag, "_busy_on"}, 32'(busy[i]), 32'd1);
  endtask

  // Checks every clk of the frame against the expected bit pattern, then the idle cycle after.
  task automatic runFrame(input int i, input logic [7:0] b, input int par, input int stops, input string tag);
    logic [15:0] fb;
    int n;
    int ok;
    int busy_cnt;
    fb    = '1;
    fb[0] = 1'b0;
    for (int k = 0; k < 8; k++) fb[1+k] = b[k];
    n = 9;
    if (par != 0) begin
      fb[9] = (par == 1) ? ^b : ~(^b);
      n = 10;
    end
    n = n + stops;
    busy_cnt = 0;
    for (int bi = 0; bi < n; bi++) begin
      ok = 0;
      for (int c = 0; c < 16; c++) begin
        if (txd[i] === fb[bi]) ok++;
        if (busy[i] === 1'b1) busy_cnt++;
        @(negedge clk);
      end
      checkOutput($sformatf("%s_bit%0d", tag, bi), 32'(ok), 32'd16);
    end
    checkOutput({tag, "_busy_clks"}, 32'(busy_cnt), 32'(n * 16));
    checkOutput({tag, "_end_busy"}, 32'(busy[i]), 32'd0);
    checkOutput({tag, "_end_baud_en"}, 32'(baud_en[i]), 32'd0);
    checkOutput({tag, "_end_txd"}, 32'(txd[i]), 32'd1);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int activity;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 2'b00;
      data[i]  = 16'h0000;
      spur[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rst%0d_txd", i), 32'(txd[i]), 32'd1);
      checkOutput($sformatf("rst%0d_baud_en", i), 32'(baud_en[i]), 32'd0);
      checkOutput($sformatf("rst%0d_busy", i), 32'(busy[i]), 32'd0);
      checkOutput($sformatf("rst%0d_gid", i), 32'(gid[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single byte 8'hA5 from requester 0");
    acceptFrame(0, 2'b01, 16'h00A5, 2'b01, 1'b0, "single");
    applyStimulus(0, 2'b00, 16'h0000);
    runFrame(0, 8'hA5, 0, 1, "single");

    $display("[TB] round-robin with both requesters held valid");
    pulseReset();
    acceptFrame(0, 2'b11, 16'h2211, 2'b01, 1'b0, "rr0");
    runFrame(0, 8'h11, 0, 1, "rr0");
    acceptFrame(0, 2'b11, 16'h2211, 2'b10, 1'b1, "rr1");
    runFrame(0, 8'h22, 0, 1, "rr1");
    acceptFrame(0, 2'b11, 16'h2211, 2'b01, 1'b0, "rr2");
    runFrame(0, 8'h11, 0, 1, "rr2");
    acceptFrame(0, 2'b11, 16'h2211, 2'b10, 1'b1, "rr3");
    applyStimulus(0, 2'b00, 16'h0000);
    runFrame(0, 8'h22, 0, 1, "rr3");

    $display("[TB] reset in the middle of data bit 3");
    acceptFrame(0, 2'b01, 16'h00A5, 2'b01, 1'b0, "pre");
    applyStimulus(0, 2'b00, 16'h0000);
    runFrame(0, 8'hA5, 0, 1, "pre");
    acceptFrame(0, 2'b10, 16'h3300, 2'b10, 1'b1, "abort");
    applyStimulus(0, 2'b00, 16'h0000);
    repeat (70) @(negedge clk);
    checkOutput("abort_txd_bit3", 32'(txd[0]), 32'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_txd", 32'(txd[0]), 32'd1);
    checkOutput("abort_baud_en", 32'(baud_en[0]), 32'd0);
    checkOutput("abort_busy", 32'(busy[0]), 32'd0);
    checkOutput("abort_gid", 32'(gid[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acceptFrame(0, 2'b11, 16'h2211, 2'b01, 1'b0, "post_rst");
    applyStimulus(0, 2'b00, 16'h0000);
    runFrame(0, 8'h11, 0, 1, "post_rst");

    $display("[TB] spurious ticks in IDLE and a withdrawn request");
    activity = 0;
    for (int c = 0; c < 40; c++) begin
      spur[0] = (c % 5 == 2);
      if (c == 20) begin
        valid[0] = 2'b10;
        #2 valid[0] = 2'b00;
      end
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || baud_en[0] !== 1'b0 || ready[0] !== 2'b00) activity++;
    end
    spur[0] = 1'b0;
    checkOutput("idle_activity", 32'(activity), 32'd0);
    acceptFrame(0, 2'b11, 16'h2211, 2'b10, 1'b1, "after_wd");
    applyStimulus(0, 2'b00, 16'h0000);
    runFrame(0, 8'h22, 0, 1, "after_wd");

    $display("[TB] even and odd parity, byte 8'h07");
    acceptFrame(1, 2'b01, 16'h0007, 2'b01, 1'b0, "even");
    applyStimulus(1, 2'b00, 16'h0000);
    runFrame(1, 8'h07, 1, 1, "even");
    acceptFrame(2, 2'b01, 16'h0007, 2'b01, 1'b0, "odd");
    applyStimulus(2, 2'b00, 16'h0000);
    runFrame(2, 8'h07, 2, 1, "odd");

    $display("[TB] two stop bits, byte 8'hFF");
    acceptFrame(3, 2'b01, 16'h00FF, 2'b01, 1'b0, "stop2");
    applyStimulus(3, 2'b00, 16'h0000);
    runFrame(3, 8'hFF, 0, 2, "stop2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
